typing_engine: RTL

Parametrised typing-test core, successor to the fixed-size typing-test system. It streams a NUL-terminated prompt from an external ROM out through the UART TX handshake, then starts a BCD timer on carriage return. It scores each UART RX byte against the prompt and freezes the timer when the prompt length has been typed. It sits between the UART RX/TX pair, the prompt ROM and the display/score logic.

---
 rtl/typing_pkg.sv | 19 +
 rtl/bcd_timer.sv | 65 ++++++
 rtl/typing_engine.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/typing_pkg.sv
// typing_pkg: shared types and constants for the typing-test core.
//   state_t     : top-level FSM state encoding
//   CR, BS, NUL : ASCII control characters the core reacts to
package typing_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT_ROM,
        S_SEND,
        S_WAIT_START,
        S_TYPING,
        S_DONE
    } state_t;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] NUL = 8'h00;

endpackage

// File: rtl/bcd_timer.sv
// bcd_timer: tick divider plus saturating packed-BCD elapsed-time counter.
//   i_clk, i_rst (async, active-low)
//   i_clear    : zero the divider and the BCD value (has priority over i_run)
//   i_run      : advance the divider; every TICK_DIV cycles the BCD value
//                increments with decimal carry, holding at all-9s
//   o_time_bcd : TIMER_DIGITS packed BCD digits, LS digit = one tick
module bcd_timer #(
    parameter int TICK_DIV     = 5000000,
    parameter int TIMER_DIGITS = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_clear,
    input  logic                      i_run,
    output logic [4*TIMER_DIGITS-1:0] o_time_bcd
);
    localparam int DIV_W = $clog2(TICK_DIV);

    logic [DIV_W-1:0]          r_div;
    logic [4*TIMER_DIGITS-1:0] r_bcd;
    logic [4*TIMER_DIGITS-1:0] w_bcd_inc;
    logic                      w_wrap;
    logic                      w_all9;
    logic                      w_carry;

    assign w_wrap = (r_div == DIV_W'(TICK_DIV - 1));

    // Ripple-carry decimal increment; w_all9 flags the saturation point.
    always_comb begin
        w_bcd_inc = r_bcd;
        w_carry   = 1'b1;
        w_all9    = 1'b1;
        for (int d = 0; d < TIMER_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] != 4'd9) w_all9 = 1'b0;
            if (w_carry) begin
                if (r_bcd[4*d +: 4] == 4'd9) begin
                    w_bcd_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_bcd_inc[4*d +: 4] = r_bcd[4*d +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_div <= '0;
            r_bcd <= '0;
        end else if (i_clear) begin
            r_div <= '0;
            r_bcd <= '0;
        end else if (i_run) begin
            if (w_wrap) begin
                r_div <= '0;
                if (!w_all9) r_bcd <= w_bcd_inc;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_time_bcd = r_bcd;

endmodule

// File: rtl/typing_engine.sv
// typing_engine: typing-test core. Prints a NUL-terminated prompt from an
// external 1-cycle-latency ROM over the UART TX handshake, starts a BCD
// timer on CR, scores each received byte against the prompt (echoing it),
// and freezes the timer once the prompt length has been typed.
//
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_rx_valid/i_rx_byte : received character pulse
//   i_tx_done            : UART TX completion pulse
//   o_tx_go/o_tx_byte    : transmit request pulse, byte held until done
//   o_rom_addr/i_rom_data: prompt ROM read port
//   o_time_bcd           : elapsed time, packed BCD
//   o_correct_cnt/o_error_cnt : current scoring
//   o_typing, o_done     : timer running / test complete
//   o_overrun            : sticky, an echo was dropped
//
// Build option: TYPING_BACKSPACE_EN enables backspace (0x08) handling in
// TYPING; without it 0x08 is scored like any other byte.
module typing_engine import typing_pkg::*; #(
    parameter  int PROMPT_LEN   = 64,
    parameter  int TICK_DIV     = 5000000,
    parameter  int TIMER_DIGITS = 3,
    localparam int ADDR_W       = $clog2(PROMPT_LEN + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rx_valid,
    input  logic [7:0]                i_rx_byte,
    input  logic                      i_tx_done,
    output logic                      o_tx_go,
    output logic [7:0]                o_tx_byte,
    output logic [ADDR_W-1:0]         o_rom_addr,
    input  logic [7:0]                i_rom_data,
    output logic [4*TIMER_DIGITS-1:0] o_time_bcd,
    output logic [ADDR_W-1:0]         o_correct_cnt,
    output logic [ADDR_W-1:0]         o_error_cnt,
    output logic                      o_typing,
    output logic                      o_done,
    output logic                      o_overrun
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_rom_addr, r_prompt_len, r_correct, r_error;
    logic              r_tx_go, r_tx_busy, r_pend_vld;
    logic [7:0]        r_tx_byte, r_pend_byte;
    logic              r_typing, r_done, r_overrun;

    logic [ADDR_W-1:0] w_addr_inc;
    logic              w_clr, w_echo, w_is_bs, w_tx_free, w_drain, w_match;

`ifdef TYPING_BACKSPACE_EN
    logic [PROMPT_LEN-1:0] r_result;
    logic                  w_prev_ok;

    always_comb begin
        w_prev_ok = 1'b0;
        for (int i = 0; i < PROMPT_LEN; i++)
            if (r_rom_addr == ADDR_W'(i + 1)) w_prev_ok = r_result[i];
    end
`endif

    assign w_addr_inc = r_rom_addr + 1'b1;
    assign w_match    = (i_rx_byte == i_rom_data);

    always_comb begin
        w_is_bs = 1'b0;
`ifdef TYPING_BACKSPACE_EN
        w_is_bs = (i_rx_byte == BS);
`endif
        w_clr = 1'b0;
        if (i_rx_valid && i_rx_byte == CR) begin
            if (r_state == S_WAIT_START) w_clr = 1'b1;
            // Reprint only once the echo path has fully drained.
            if (r_state == S_DONE && !r_tx_busy && !r_pend_vld) w_clr = 1'b1;
        end
        // Backspace at position 0 is silently ignored, no echo.
        w_echo = (r_state == S_TYPING) && i_rx_valid && (!w_is_bs || r_rom_addr != '0);
    end

    // A tx_done this cycle frees the UART; a pending byte has first claim on it.
    assign w_tx_free = (!r_tx_busy || i_tx_done) && !r_pend_vld;
    assign w_drain   = r_pend_vld && i_tx_done;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_FETCH;
            r_rom_addr   <= '0;
            r_prompt_len <= '0;
            r_correct    <= '0;
            r_error      <= '0;
            r_tx_go      <= 1'b0;
            r_tx_byte    <= 8'h00;
            r_tx_busy    <= 1'b0;
            r_pend_vld   <= 1'b0;
            r_pend_byte  <= 8'h00;
            r_typing     <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef TYPING_BACKSPACE_EN
            r_result     <= '0;
`endif
        end else begin
            r_tx_go <= 1'b0;
            if (i_tx_done) r_tx_busy <= 1'b0;

            // Echo path: later assignments override, so a same-cycle drain
            // and refill of the pending slot needs no special case.
            if (w_drain) begin
                r_tx_go    <= 1'b1;
                r_tx_byte  <= r_pend_byte;
                r_tx_busy  <= 1'b1;
                r_pend_vld <= 1'b0;
            end
            if (w_echo) begin
                if (w_tx_free) begin
                    r_tx_go   <= 1'b1;
                    r_tx_byte <= i_rx_byte;
                    r_tx_busy <= 1'b1;
                end else if (!r_pend_vld || w_drain) begin
                    r_pend_vld  <= 1'b1;
                    r_pend_byte <= i_rx_byte;
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            case (r_state)
                S_FETCH: r_state <= S_WAIT_ROM;
                S_WAIT_ROM: begin
                    if (i_rom_data == NUL || r_rom_addr == ADDR_W'(PROMPT_LEN)) begin
                        r_prompt_len <= r_rom_addr;
                        r_rom_addr   <= '0;
                        r_state      <= S_WAIT_START;
                    end else begin
                        r_tx_go   <= 1'b1;
                        r_tx_byte <= i_rom_data;
                        r_tx_busy <= 1'b1;
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (i_tx_done) begin
                        r_rom_addr <= w_addr_inc;
                        r_state    <= S_FETCH;
                    end
                end
                S_WAIT_START: begin
                    if (w_clr) begin
                        r_correct <= '0;
                        r_error   <= '0;
                        if (r_prompt_len == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_typing <= 1'b1;
                            r_state  <= S_TYPING;
                        end
                    end
                end
                S_TYPING: begin
                    if (i_rx_valid) begin
                        if (w_is_bs) begin
`ifdef TYPING_BACKSPACE_EN
                            if (r_rom_addr != '0) begin
                                r_rom_addr <= r_rom_addr - 1'b1;
                                if (w_prev_ok) r_correct <= r_correct - 1'b1;
                                else           r_error   <= r_error - 1'b1;
                            end
`endif
                        end else begin
                            if (w_match) r_correct <= r_correct + 1'b1;
                            else         r_error   <= r_error + 1'b1;
`ifdef TYPING_BACKSPACE_EN
                            for (int i = 0; i < PROMPT_LEN; i++)
                                if (r_rom_addr == ADDR_W'(i)) r_result[i] <= w_match;
`endif
                            r_rom_addr <= w_addr_inc;
                            if (w_addr_inc == r_prompt_len) begin
                                r_typing <= 1'b0;
                                r_done   <= 1'b1;
                                r_state  <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (w_clr) begin
                        r_correct  <= '0;
                        r_error    <= '0;
                        r_overrun  <= 1'b0;
                        r_rom_addr <= '0;
                        r_done     <= 1'b0;
                        r_state    <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    bcd_timer #(
        .TICK_DIV     (TICK_DIV),
        .TIMER_DIGITS (TIMER_DIGITS)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (w_clr),
        .i_run      (r_typing),
        .o_time_bcd (o_time_bcd)
    );

    assign o_tx_go       = r_tx_go;
    assign o_tx_byte     = r_tx_byte;
    assign o_rom_addr    = r_rom_addr;
    assign o_correct_cnt = r_correct;
    assign o_error_cnt   = r_error;
    assign o_typing      = r_typing;
    assign o_done        = r_done;
    assign o_overrun     = r_overrun;

endmodule
